// File: rtl/led_pio_blink.sv
// led_pio_blink
//   Avalon-MM output PIO for the LED bank. It provides a DATA register with
//   atomic set/clear/toggle aliases, per-bit blink enables (MODE), a
//   programmable blink half-period (PERIOD) and a registered LED drive.
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   reset       synchronous, active-high
//   address     register select (0 DATA, 1 MODE, 2 OUTSET, 3 OUTCLEAR,
//               4 TOGGLE, 5 PERIOD, 6 STATUS, 7 reserved)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data; bits above WIDTH / PERIOD_W are dropped
//   readdata    combinational read data selected by address, zero-extended
//   out_port    registered LED drive
//
// Handshake: there is no waitrequest. A write is accepted on every rising
// edge where chipselect && !write_n. Reads are side-effect free and
// readdata is valid in the same cycle as address.

module led_pio_blink #(
  parameter int unsigned          WIDTH          = 8,
  parameter int unsigned          PERIOD_W       = 24,
  parameter logic [WIDTH-1:0]     RESET_VALUE    = '0,
  parameter logic [PERIOD_W-1:0]  DEFAULT_PERIOD = PERIOD_W'(12499999)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_SET    = 3'd2;
  localparam logic [2:0] ADDR_CLEAR  = 3'd3;
  localparam logic [2:0] ADDR_TOGGLE = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  logic [WIDTH-1:0]    r_data;
  logic [WIDTH-1:0]    r_mode;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_phase;
  logic [WIDTH-1:0]    r_out;

  logic                w_wr;
  logic [WIDTH-1:0]    w_wd_data;
  logic [PERIOD_W-1:0] w_wd_period;
  logic [WIDTH-1:0]    w_data_next;
  logic [WIDTH-1:0]    w_mode_next;
  logic [PERIOD_W-1:0] w_period_next;
  logic [PERIOD_W-1:0] w_cnt_next;
  logic                w_phase_next;
  logic [WIDTH-1:0]    w_out_next;
  logic [31:0]         w_readdata;
  logic                w_unused_wd;

  assign w_wr        = chipselect & ~write_n;
  assign w_wd_data   = writedata[WIDTH-1:0];
  assign w_wd_period = writedata[PERIOD_W-1:0];
  // Upper writedata bits are intentionally dropped.
  assign w_unused_wd = &{1'b0, writedata};

  always_comb begin
    w_data_next   = r_data;
    w_mode_next   = r_mode;
    w_period_next = r_period;
    w_cnt_next    = r_cnt;
    w_phase_next  = r_phase;

    if (w_wr) begin
      case (address)
        ADDR_DATA:   w_data_next = w_wd_data;
        ADDR_MODE:   w_mode_next = w_wd_data;
        ADDR_SET:    w_data_next = r_data | w_wd_data;
        ADDR_CLEAR:  w_data_next = r_data & ~w_wd_data;
        ADDR_TOGGLE: w_data_next = r_data ^ w_wd_data;
        default:     ;
      endcase
    end

    // A PERIOD write reloads the counter immediately and wins over this
    // cycle's decrement/reload; the phase is left untouched.
    if (w_wr && (address == ADDR_PERIOD)) begin
      w_period_next = w_wd_period;
      w_cnt_next    = w_wd_period;
    end else if (r_cnt == '0) begin
      w_cnt_next   = r_period;
      w_phase_next = ~r_phase;
    end else begin
      w_cnt_next = r_cnt - PERIOD_W'(1);
    end

    // Blinking bits are blanked while the phase is low. Using the _next
    // values makes a register write visible on out_port one cycle later.
    w_out_next = w_data_next & ~(w_mode_next & {WIDTH{~w_phase_next}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= RESET_VALUE;
      r_mode   <= '0;
      r_period <= DEFAULT_PERIOD;
      r_cnt    <= DEFAULT_PERIOD;
      r_phase  <= 1'b1;
      r_out    <= RESET_VALUE;
    end else begin
      r_data   <= w_data_next;
      r_mode   <= w_mode_next;
      r_period <= w_period_next;
      r_cnt    <= w_cnt_next;
      r_phase  <= w_phase_next;
      r_out    <= w_out_next;
    end
  end

  always_comb begin
    w_readdata = '0;
    case (address)
      ADDR_DATA:   w_readdata[WIDTH-1:0]    = r_data;
      ADDR_MODE:   w_readdata[WIDTH-1:0]    = r_mode;
      ADDR_PERIOD: w_readdata[PERIOD_W-1:0] = r_period;
      ADDR_STATUS: w_readdata[0]            = r_phase;
      default:     ;
    endcase
  end

  assign readdata = w_readdata;
  assign out_port = r_out;

endmodule
